// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, shadow entry sizing and the
// all-zero control word used for bubbles by both the hazard unit and the control block.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } hazState_t;

  localparam int DEF_REG_W = 5;
  localparam int SHADOW_W  = DEF_REG_W + 2;

  // A shadow entry is {dest, memRead, regWrite}.
  function automatic int shadowWidth(input int regW);
    return regW + 2;
  endfunction

  localparam int                CTRL_W      = 9;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/haz_shadow_stage.sv
// One registered shadow entry {dest, memRead, regWrite} with asynchronous
// active-low clear and a synchronous zero used for bubbles and flushes.
module haz_shadow_stage
  import hazard_unit_pkg::*;
#(
  parameter int ENT_W = SHADOW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [ENT_W-1:0] d,
  output logic [ENT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clear)
      q <= '0;
    else
      q <= d;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection and flush control for the five-stage MIPS datapath.
// Build option: define HAZ_FORWARD_EN for load-use-only stalls; otherwise full RAW stalls.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic              idUsesRt,
  input  logic [REG_W-1:0]  idDest,
  input  logic              idMemRead,
  input  logic              idRegWrite,
  input  logic              idJ,
  input  logic              memBranchTaken,
  output logic              stall,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              ifidFlush,
  output logic              idexFlush,
  output logic              exmemFlush,
  output logic [PERF_W-1:0] stallCycles
);

  localparam int ENT_W = shadowWidth(REG_W);

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             memRead;
    logic             regWrite;
  } entry_t;

  entry_t    idEnt, exEnt, memEnt, wbEnt;
  hazState_t state;
  logic [1:0] holdCnt;
  logic      hazard, branch, bubble;

  // Entries writing $0 or not writing at all can never be producers.
  function automatic logic entryMatches(input entry_t e, input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rt, input logic usesRt);
    return e.regWrite && (e.dest != '0) && ((e.dest == rs) || (usesRt && (e.dest == rt)));
  endfunction

  always_comb begin
    idEnt = '{dest: idDest, memRead: idMemRead, regWrite: idRegWrite};
`ifdef HAZ_FORWARD_EN
    hazard = exEnt.memRead && entryMatches(exEnt, idRs, idRt, idUsesRt);
`else
    hazard = entryMatches(exEnt,  idRs, idRt, idUsesRt) ||
             entryMatches(memEnt, idRs, idRt, idUsesRt) ||
             entryMatches(wbEnt,  idRs, idRt, idUsesRt);
`endif
    branch = memBranchTaken;
    bubble = hazard && !branch;

    stall      = !(branch || hazard);
    pcWrite    = branch || !hazard;
    ifidWrite  = branch || !hazard;
    ifidFlush  = branch || (idJ && !hazard);
    idexFlush  = branch;
    exmemFlush = branch;
  end

  haz_shadow_stage #(.ENT_W(ENT_W)) exStage (
    .clk(clk), .rst_n(rst_n), .clear(branch || hazard), .d(idEnt), .q(exEnt)
  );

  haz_shadow_stage #(.ENT_W(ENT_W)) memStage (
    .clk(clk), .rst_n(rst_n), .clear(branch), .d(exEnt), .q(memEnt)
  );

  haz_shadow_stage #(.ENT_W(ENT_W)) wbStage (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .d(memEnt), .q(wbEnt)
  );

  // A taken branch overrides any stall; flushed stall cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      holdCnt     <= 2'd0;
      stallCycles <= '0;
    end else begin
      if (branch) begin
        state   <= FLUSH;
        holdCnt <= 2'd0;
      end else begin
        case (state)
          RUN: begin
            if (hazard) begin
              state   <= HOLD;
              holdCnt <= 2'd1;
            end
          end
          HOLD: begin
            if (hazard) begin
              if (holdCnt != 2'd3)
                holdCnt <= holdCnt + 2'd1;
            end else begin
              state   <= RUN;
              holdCnt <= 2'd0;
            end
          end
          default: begin
            state   <= RUN;
            holdCnt <= 2'd0;
          end
        endcase
      end
      if (bubble && (stallCycles != '1))
        stallCycles <= stallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; expectations follow HAZ_FORWARD_EN
// so the same bench covers both builds.
module tb_hazard_unit;

  localparam int REG_W  = 5;
  localparam int PERF_W = 4;
`ifdef HAZ_FORWARD_EN
  localparam int LU_BUB  = 1;
  localparam int RAW_BUB = 0;
`else
  localparam int LU_BUB  = 3;
  localparam int RAW_BUB = 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_W-1:0]  idRs, idRt, idDest;
  logic              idUsesRt, idMemRead, idRegWrite, idJ, memBranchTaken;
  logic              stall, pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush;
  logic [PERF_W-1:0] stallCycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_W(REG_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt), .idDest(idDest),
    .idMemRead(idMemRead), .idRegWrite(idRegWrite), .idJ(idJ),
    .memBranchTaken(memBranchTaken),
    .stall(stall), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .stallCycles(stallCycles)
  );

  task automatic setIdle();
    idRs = '0; idRt = '0; idUsesRt = 1'b0; idDest = '0;
    idMemRead = 1'b0; idRegWrite = 1'b0; idJ = 1'b0; memBranchTaken = 1'b0;
  endtask

  task automatic setProducer(input logic [REG_W-1:0] dest, input logic isLoad);
    setIdle();
    idDest = dest; idRegWrite = 1'b1; idMemRead = isLoad;
  endtask

  task automatic setReader(input logic [REG_W-1:0] rs);
    setIdle();
    idRs = rs; idRt = 5'd0; idUsesRt = 1'b1; idDest = 5'd10; idRegWrite = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    setIdle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Holds the current ID inputs until stall returns to 1; leaves time at negedge+1.
  task automatic countBubbles(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL bubbleTimeout: stall stuck at %b, required 1 within 8 cycles", stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setIdle();
    #12;
    checks++;
    if ({stall, pcWrite, ifidWrite} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL resetEnables: got %b required 111", {stall, pcWrite, ifidWrite});
    end
    checks++;
    if ({ifidFlush, idexFlush, exmemFlush} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL resetFlushes: got %b required 000", {ifidFlush, idexFlush, exmemFlush});
    end
    checks++;
    if (stallCycles !== '0) begin
      errors++;
      $display("[TB] FAIL resetCount: got %0d required 0", stallCycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    int n;
    doReset();
    setProducer(5'd8, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loadUseProducer: stall=%b required 1", stall);
    end
    @(negedge clk);
    setReader(5'd8);
    #1;
    checks++;
    if ({stall, pcWrite, ifidWrite} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL loadUseBubble: stall/pcWrite/ifidWrite=%b required 000",
               {stall, pcWrite, ifidWrite});
    end
    countBubbles(n);
    checks++;
    if (n !== LU_BUB) begin
      errors++;
      $display("[TB] FAIL loadUseBubbles: got %0d required %0d", n, LU_BUB);
    end
    @(negedge clk);
    setReader(5'd8);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loadUseBackToBack: stall=%b required 1", stall);
    end
    checks++;
    if (stallCycles !== PERF_W'(LU_BUB)) begin
      errors++;
      $display("[TB] FAIL loadUseCount: got %0d required %0d", stallCycles, LU_BUB);
    end
  endtask

  task automatic test_raw();
    int n;
    doReset();
    setProducer(5'd9, 1'b0);
    @(negedge clk);
    setReader(5'd9);
    countBubbles(n);
    checks++;
    if (n !== RAW_BUB) begin
      errors++;
      $display("[TB] FAIL rawBubbles: got %0d required %0d", n, RAW_BUB);
    end
    checks++;
    if (stallCycles !== PERF_W'(RAW_BUB)) begin
      errors++;
      $display("[TB] FAIL rawCount: got %0d required %0d", stallCycles, RAW_BUB);
    end
  endtask

  task automatic test_reg_zero();
    int n;
    doReset();
    setProducer(5'd0, 1'b1);
    @(negedge clk);
    setReader(5'd0);
    countBubbles(n);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("[TB] FAIL regZeroBubbles: got %0d required 0", n);
    end
    checks++;
    if (stallCycles !== '0) begin
      errors++;
      $display("[TB] FAIL regZeroCount: got %0d required 0", stallCycles);
    end
  endtask

  task automatic test_branch_during_stall();
    doReset();
    setProducer(5'd8, 1'b1);
    @(negedge clk);
    setReader(5'd8);
    memBranchTaken = 1'b1;
    #1;
    checks++;
    if ({ifidFlush, idexFlush, exmemFlush} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL branchFlushes: got %b required 111", {ifidFlush, idexFlush, exmemFlush});
    end
    checks++;
    if ({stall, pcWrite} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL branchStallPc: stall/pcWrite=%b required 01", {stall, pcWrite});
    end
    @(negedge clk);
    setReader(5'd8);
    #1;
    checks++;
    if ({stall, ifidFlush, idexFlush, exmemFlush} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL branchAfter: stall/flushes=%b required 1000",
               {stall, ifidFlush, idexFlush, exmemFlush});
    end
    checks++;
    if (stallCycles !== '0) begin
      errors++;
      $display("[TB] FAIL branchCount: got %0d required 0", stallCycles);
    end
  endtask

  task automatic test_jump();
    doReset();
    idJ = 1'b1;
    #1;
    checks++;
    if ({ifidFlush, idexFlush, stall, pcWrite} !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL jumpCycle: ifidFlush/idexFlush/stall/pcWrite=%b required 1011",
               {ifidFlush, idexFlush, stall, pcWrite});
    end
    @(negedge clk);
    setIdle();
    #1;
    checks++;
    if ({ifidFlush, stall, pcWrite} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL jumpAfter: ifidFlush/stall/pcWrite=%b required 011",
               {ifidFlush, stall, pcWrite});
    end
    setProducer(5'd8, 1'b1);
    @(negedge clk);
    setReader(5'd8);
    idJ = 1'b1;
    #1;
    checks++;
    if ({ifidFlush, stall} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL jumpUnderHazard: ifidFlush/stall=%b required 00", {ifidFlush, stall});
    end
  endtask

  task automatic test_reset_mid_hold();
    doReset();
    setProducer(5'd8, 1'b1);
    @(negedge clk);
    setReader(5'd8);
    if (LU_BUB > 1) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midHoldStall: stall=%b required 0", stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush} !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL midHoldReset: outputs=%b required 111000",
               {stall, pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush});
    end
    checks++;
    if (stallCycles !== '0) begin
      errors++;
      $display("[TB] FAIL midHoldCount: got %0d required 0", stallCycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL afterResetRelease: stall=%b required 1", stall);
    end
  endtask

  task automatic test_back_to_back_saturate();
    int n;
    doReset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      setProducer(5'd8, 1'b1);
      @(negedge clk);
      setReader(5'd8);
      countBubbles(n);
    end
    checks++;
    if (stallCycles !== 4'hF) begin
      errors++;
      $display("[TB] FAIL saturate: got %0d required 15", stallCycles);
    end
  endtask

  initial begin
    setIdle();
    test_reset();
    test_load_use();
    test_raw();
    test_reg_zero();
    test_branch_during_stall();
    test_jump();
    test_reset_mid_hold();
    test_back_to_back_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detection and flush control for the five-stage MIPS datapath. It is the producer of the `stall` input consumed by the pipelined control block. It also drives the PC and IF/ID write enables and the IF/ID, ID/EX and EX/MEM flush lines. It keeps its own shadow copy of destination-register and load/write flags for EX, MEM and WB, so dependencies are detected without tapping datapath registers.

## Interface
- `REG_W`, default 5: register-specifier width.
- `PERF_W`, default 16: stall-cycle counter width.
- `clk`, in, 1: single pipeline clock; all state updates on posedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `idRs`, `idRt`, in, REG_W each: source specifiers of the instruction in ID.
- `idUsesRt`, in, 1: the ID instruction reads rt (R-type, beq, sw).
- `idDest`, in, REG_W: post-regDst destination of the ID instruction.
- `idMemRead`, `idRegWrite`, in, 1 each: ID instruction is a load, or writes the register file.
- `idJ`, in, 1: the ID instruction is j (resolved in ID).
- `memBranchTaken`, in, 1: branch in MEM is taken this cycle.
- `stall`, out, 1: control-path select. 1 = pass decoded control into ID/EX; 0 = insert bubble (all-zero control).
- `pcWrite`, `ifidWrite`, out, 1 each: PC and IF/ID load enables.
- `ifidFlush`, `idexFlush`, `exmemFlush`, out, 1 each: synchronous clears of those pipeline registers.
- `stallCycles`, out, PERF_W: saturating count of bubble cycles since reset.

## Operation
- **Shadow pipe:** three entries `{dest, memRead, regWrite}` for EX, MEM and WB. They shift each posedge: EX←ID (or zero on a bubble or flush), MEM←EX, WB←MEM.
  - An entry with dest==0 or regWrite==0 never produces a hazard.
- **Consumer match:** an entry matches if its dest equals `idRs`, or equals `idRt` when `idUsesRt` is set.
- **Hazard rule with forwarding:** only a load in EX matching ID causes a hazard. This gives a one-bubble stall.
- **Hazard rule without forwarding:** any matching entry in EX, MEM or WB causes a hazard. WB counts because the register file writes at the posedge, not mid-cycle. The stall lasts until the producer leaves WB, so 1 to 3 bubbles.
- **On a hazard:** `stall`=0, `pcWrite`=0, `ifidWrite`=0, and the EX shadow entry is loaded with zero.
- **FSM states:**
  - RUN: no hazard.
  - HOLD: hazard present. A 2-bit counter `holdCnt` counts bubbles, saturating at 3.
  - FLUSH: one cycle following a taken branch.
- **Transitions:**
  - RUN→HOLD when a hazard is detected.
  - HOLD→RUN when the hazard clears.
  - Any→FLUSH when `memBranchTaken`=1.
  - FLUSH→RUN unconditionally.
- **Taken branch** (combinational in the same cycle as `memBranchTaken`):
  - `ifidFlush`=`idexFlush`=`exmemFlush`=1.
  - `stall`=0.
  - `pcWrite`=1, so the branch target loads.
  - The EX and MEM shadow entries are zeroed.
- **Priority:** branch flush > hazard stall > jump.
- **Jump:** `idJ`=1 with no hazard raises `ifidFlush` for that cycle only. The fetched slot is discarded and there is no stall.
- **`stallCycles`:** increments on every cycle with `stall`=0 caused by a hazard (flush cycles are not counted). Saturates at all-ones.

## Timing
- Hazard outputs are combinational from the ID inputs and the shadow registers. They are valid in the same cycle the dependent instruction sits in ID.
- State, shadow and counter are registered.
- Reset values:
  - Shadow entries all zero, state RUN, `holdCnt`=0, `stallCycles`=0.
  - Outputs with all inputs at zero: `stall`=1, `pcWrite`=1, `ifidWrite`=1, all flushes 0.
- Reset asserted mid-HOLD or mid-FLUSH returns to RUN immediately and drops all pending bubbles.
- Load-use back-to-back (a dependent instruction after a stalled dependent) produces no second stall. After one bubble the load is in MEM, which the forwarding unit covers.
- A hazard and `memBranchTaken` in the same cycle resolve to FLUSH. The stalled instruction is discarded and is not counted in `stallCycles`.

## Configuration
- `HAZ_FORWARD_EN` defined: the forwarding rule applies. Only load-use stalls, and HOLD never exceeds 1 cycle.
- `HAZ_FORWARD_EN` undefined: the no-forwarding rule applies, with full RAW stalls up to 3 cycles.

## Structure
- The shared pipeline package holds:
  - the FSM state encoding (RUN=2'd0, HOLD=2'd1, FLUSH=2'd2);
  - the shadow entry width constant (REG_W+2);
  - the zero-control bubble constant, shared with the control block.
- One sub-module, `haz_shadow_stage`: a registered `{dest, memRead, regWrite}` entry with async active-low clear and synchronous zero. It is instantiated three times.

## Test plan
1. **Load-use:**
   - Stimulus: lw $8 in ID (idMemRead=1, idDest=8), then add with idRs=8.
   - Required response: exactly one cycle of `stall`=0, `pcWrite`=0, `ifidWrite`=0; `stallCycles`=1.
2. **No-forward RAW:**
   - Stimulus: `HAZ_FORWARD_EN` undefined; add $9 followed immediately by a reader of rs=9.
   - Required response: 3 bubble cycles, then `stall`=1; `stallCycles`=3.
3. **Register zero:**
   - Stimulus: a producer with idDest=0 followed by a reader of rs=0.
   - Required response: no stall, in both configurations.
4. **Taken branch during a stall:**
   - Stimulus: `memBranchTaken`=1 in the same cycle as a load-use hazard.
   - Required response: all three flushes 1, `pcWrite`=1; the next cycle is RUN; `stallCycles` unchanged.
5. **Jump:**
   - Stimulus: `idJ`=1.
   - Required response: `ifidFlush`=1 for one cycle; `stall`=1 and `pcWrite`=1 throughout.
6. **Reset mid-HOLD:**
   - Stimulus: assert `rst_n`=0 asynchronously while in the second bubble.
   - Required response: outputs return to the reset values immediately; `stallCycles`=0.
